mem_arbiter: RTL and testbench

Single-port memory arbiter sharing one RAM port between the instruction-fetch and data ports of the pipelined datapath. It sits between the caches/datapath request side and the RAM model. Data accesses have priority so the MEM stage is never starved. It sequences each access through a grant FSM with a watchdog timeout, and reports RAM faults.

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter                                                              |
// | Shares one RAM port between instruction fetch and data access; data has  |
// | priority, each grant is watchdog-timed, and RAM faults latch FAULT.      |
// | Optional: ARB_STARVE_GUARD_EN bounds fetch starvation by STARVE_LIMIT.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t            state;
  state_t            arb_next;
  logic [WCNT_W-1:0] wcnt;
  logic              data_req;
  logic              req_live;
  logic              access;
  logic              fetch_first;

  assign data_req = dREN | dWEN;
  assign req_live = (state == DGRANT) ? data_req : iREN;
  assign access   = ((state == DGRANT) || (state == IGRANT)) && (ramstate == RAM_ACCESS);

`ifdef ARB_STARVE_GUARD_EN
  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_eff;

  // The completing data access counts toward the streak before arbitrating,
  // so fetch wins right after the STARVE_LIMIT-th data completion.
  always_comb begin
    streak_eff = streak;
    if ((state == DGRANT) && access && iREN && (streak != STREAK_MAX))
      streak_eff = streak + 1'b1;
  end

  assign fetch_first = iREN && (streak_eff == STREAK_MAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      streak <= '0;
    else if (!iREN)
      streak <= '0;
    else if (((state == IDLE) || access) && (arb_next == IGRANT))
      streak <= '0;
    else
      streak <= streak_eff;
  end
`else
  // Strict data priority: the override can never fire for a legal limit.
  assign fetch_first = iREN && (STARVE_LIMIT < 0);
`endif

  always_comb begin
    if (fetch_first)
      arb_next = IGRANT;
    else if (data_req)
      arb_next = DGRANT;
    else if (iREN)
      arb_next = IGRANT;
    else
      arb_next = IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= arb_next;
          wcnt  <= '0;
        end
        DGRANT, IGRANT: begin
          if (ramstate == RAM_ERROR) begin
            state <= FAULT;
          end else if (ramstate == RAM_ACCESS) begin
            state <= arb_next;
            wcnt  <= '0;
          end else if (!req_live) begin
            state <= IDLE;
            wcnt  <= '0;
          end else if (wcnt == WCNT_LAST) begin
            state <= FAULT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        FAULT: state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (access) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (access) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

  assign err = (state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter                                                           |
// | Directed scenarios plus randomized two-port traffic against a RAM model; |
// | load data is checked by per-port scoreboards. Revision: 1.0              |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [1:0]  ramstate;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic        ram_auto = 1'b0;
  logic        sb_en    = 1'b0;
  logic [1:0]  man_state = FREE;
  logic [31:0] man_load  = '0;
  logic [31:0] ram_mem   [0:255];
  logic [31:0] model_mem [0:127];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          i_cnt = 0;
  int          d_cnt = 0;

  localparam logic [159:0] RESET_OUTS = {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0};

  function automatic logic [31:0] init_val(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [159:0] outs();
    return {ramREN, ramWEN, ramaddr, ramstore, iload, dload, iwait, dwait, err};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: answers after 0..3 BUSY cycles in auto mode, or plays man_* values.
  initial begin
    int busy_left;
    busy_left = -1;
    ramstate  = FREE;
    ramload   = '0;
    for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
    for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);
    forever begin
      @(posedge CLK); #2;
      if (!ram_auto) begin
        ramstate  = man_state;
        ramload   = man_load;
        busy_left = -1;
      end else if (!(ramREN || ramWEN)) begin
        ramstate  = FREE;
        ramload   = '0;
        busy_left = -1;
      end else begin
        if (busy_left < 0) busy_left = $urandom_range(0, 3);
        if (busy_left == 0) begin
          ramstate = ACCESS;
          ramload  = ram_mem[ramaddr[9:2]];
          if (ramWEN) ram_mem[ramaddr[9:2]] = ramstore;
          busy_left = -1;
        end else begin
          ramstate = BUSY;
          ramload  = '0;
          busy_left--;
        end
      end
    end
  end

  // Monitor: load buses are zero whenever waiting; completions pop the scoreboards.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge CLK);
      if (iwait) check("iload_idle_zero", iload, 0);
      if (dwait) check("dload_idle_zero", dload, 0);
      if (sb_en) begin
        if (!iwait && !dwait) check("single_completion", 2'b00, 2'b11);
        if (!iwait) begin
          if (iq.size() == 0) check("i_unexpected_completion", 1, 0);
          else begin
            exp = iq.pop_front();
            check("iload_data", iload, exp);
          end
          i_cnt++;
        end
        if (!dwait) begin
          if (dq.size() == 0) check("d_unexpected_completion", 1, 0);
          else begin
            exp = dq.pop_front();
            check("dload_data", dload, exp);
          end
          d_cnt++;
        end
      end
    end
  end

  task automatic drive_fetch(input int n);
    int gap, a, seen, t;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        iREN = 1'b0;
        repeat (gap) begin @(negedge CLK); #1; end
      end
      a     = $urandom_range(0, 63);
      iaddr = a * 4;
      iREN  = 1'b1;
      iq.push_back(model_mem[a]);
      seen = i_cnt;
      t    = 0;
      do begin @(negedge CLK); #1; t++; end while (i_cnt == seen && t < 4000);
      check("fetch_done_in_budget", i_cnt != seen, 1);
    end
    iREN = 1'b0;
  endtask

  task automatic drive_data(input int n);
    int gap, a, seen, t;
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        dREN = 1'b0;
        dWEN = 1'b0;
        repeat (gap) begin @(negedge CLK); #1; end
      end
      a     = $urandom_range(64, 127);
      daddr = a * 4;
      dq.push_back(model_mem[a]);
      if ($urandom_range(0, 1) == 1) begin
        v            = $urandom;
        dstore       = v;
        model_mem[a] = v;
        dWEN = 1'b1;
        dREN = 1'b0;
      end else begin
        dWEN = 1'b0;
        dREN = 1'b1;
      end
      seen = d_cnt;
      t    = 0;
      do begin @(negedge CLK); #1; t++; end while (d_cnt == seen && t < 4000);
      check("data_done_in_budget", d_cnt != seen, 1);
    end
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  initial begin
    int cnt, dc, ic, run;

    // Reset state
    @(negedge CLK);
    check("reset_outputs", outs(), RESET_OUTS);
    #1 RST = 1'b0;

    // Single fetch with ACCESS on the 2nd grant cycle
    iREN = 1'b1; iaddr = 32'h40; man_state = BUSY;
    @(negedge CLK);
    check("fetch_grant1", {ramREN, ramWEN, ramaddr, iwait}, {1'b1, 1'b0, 32'h40, 1'b1});
    #1 man_state = ACCESS; man_load = 32'h8C22_0004;
    @(negedge CLK);
    check("fetch_complete", {iwait, iload}, {1'b0, 32'h8C22_0004});
    #1 iREN = 1'b0; man_state = FREE;
    @(negedge CLK);
    check("fetch_after", {ramREN, iwait, iload}, {1'b0, 1'b1, 32'h0});

    // Simultaneous fetch and data write: data first, fetch with no bubble
    #1 iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    man_state = ACCESS; man_load = 32'h0;
    @(negedge CLK);
    check("prio_data_first", {ramWEN, ramREN, ramaddr, ramstore, dwait, iwait},
          {1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1});
    #1 dWEN = 1'b0; man_load = 32'h0000_1234;
    @(negedge CLK);
    check("prio_fetch_next", {ramREN, ramaddr, iwait, iload}, {1'b1, 32'h44, 1'b0, 32'h0000_1234});
    #1 iREN = 1'b0; man_state = FREE;
    @(negedge CLK);
    check("prio_idle", {ramREN, ramWEN, iwait, dwait}, {1'b0, 1'b0, 1'b1, 1'b1});

    // Write wins over read; withdrawal aborts without completing
    #1 dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; man_state = BUSY;
    @(negedge CLK);
    check("rw_write_wins", {ramWEN, ramREN, dwait}, {1'b1, 1'b0, 1'b1});
    #1 dREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK);
    check("abort_idle", {ramWEN, ramREN, dwait}, {1'b0, 1'b0, 1'b1});

    // Watchdog: BUSY forever in IGRANT
    #1 iREN = 1'b1; iaddr = 32'h80; man_state = BUSY;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (err) break;
      if (ramREN) cnt++;
    end
    check("timeout_grant_cycles", cnt, 64);
    check("timeout_fault", {err, ramREN, ramWEN, iwait, dwait}, 5'b10011);
    #1 iREN = 1'b0; dREN = 1'b1; daddr = 32'h10; man_state = ACCESS;
    @(negedge CLK);
    check("fault_absorbing", {err, ramREN, ramWEN, iwait, dwait}, 5'b10011);
    #1 RST = 1'b1; dREN = 1'b0; man_state = FREE;
    #1 check("fault_reset", outs(), RESET_OUTS);
    #1 RST = 1'b0;

    // Asynchronous reset mid-access
    @(negedge CLK);
    #1 dREN = 1'b1; daddr = 32'h20; man_state = BUSY;
    @(negedge CLK);
    check("midaccess_grant", ramREN, 1'b1);
    #1 RST = 1'b1;
    #1 check("midaccess_async_drop", {ramREN, dwait, err}, 3'b010);
    dREN = 1'b0;
    #1 RST = 1'b0;

    // RAM ERROR in DGRANT
    @(negedge CLK);
    #1 dREN = 1'b1; daddr = 32'h300; man_state = BUSY;
    @(negedge CLK);
    check("error_grant", {ramREN, dwait}, 2'b11);
    #1 man_state = ERROR;
    @(negedge CLK);
    check("error_cycle", {dwait, err}, 2'b10);
    @(negedge CLK);
    check("error_fault", {err, dwait, ramREN}, 3'b110);
    #1 RST = 1'b1; dREN = 1'b0; man_state = FREE;
    #1 check("error_reset", outs(), RESET_OUTS);
    #1 RST = 1'b0;

    // Continuous data and fetch requests, RAM always ready
    @(negedge CLK);
    #1 dREN = 1'b1; daddr = 32'h30; iREN = 1'b1; iaddr = 32'h34; man_state = ACCESS; man_load = '0;
    dc = 0; ic = 0; run = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (!dwait) begin dc++; run++; end
      if (!iwait) begin
        ic++;
`ifdef ARB_STARVE_GUARD_EN
        check("starve_run_length", run, 4);
`endif
        run = 0;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_counts", {dc, ic}, {32'd16, 32'd4});
`else
    check("starve_counts", {dc, ic}, {32'd20, 32'd0});
`endif
    #1 dREN = 1'b0; iREN = 1'b0; man_state = FREE;
    @(negedge CLK);
    check("starve_idle", {ramREN, ramWEN, iwait, dwait}, 4'b0011);

    // Randomized traffic on both ports
    #1 ram_auto = 1'b1; sb_en = 1'b1;
    fork
      drive_fetch(60);
      drive_data(60);
    join
    repeat (6) @(negedge CLK);
    sb_en = 1'b0;
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);
    check("fetch_completions", i_cnt, 60);
    check("data_completions", d_cnt, 60);
    for (int a = 64; a < 128; a++) check("ram_image", ram_mem[a], model_mem[a]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got %0d failures so far", fails);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
